// File: rtl/fence_if.sv
// FenceBus bundle: ROB/CSR request side plus the LSU, frontend and MMU flush handshakes.
// The sequencer uses the master modport. The slave modport is the surrounding backend.
interface fence_if #(
  parameter int VADDR_SIZE = 39,
  parameter int ASID_W     = 16
);
  logic                  req_valid;
  logic                  req_ready;
  logic [1:0]            req_type;
  logic [VADDR_SIZE-1:0] req_vaddr;
  logic [ASID_W-1:0]     req_asid;
  logic                  req_rs1_zero;
  logic                  req_rs2_zero;
  logic                  sb_drain;
  logic                  sb_empty;
  logic                  dc_wb_req;
  logic                  dc_wb_end;
  logic                  inst_flush;
  logic                  inst_flush_end;
  logic                  mmu_flush;
  logic                  mmu_flush_all;
  logic [VADDR_SIZE-1:0] vma_vaddr;
  logic [ASID_W-1:0]     vma_asid;
  logic                  mmu_flush_end;
  logic                  done;
  logic                  timeout;

  modport master (
    input  req_valid, req_type, req_vaddr, req_asid, req_rs1_zero, req_rs2_zero,
    input  sb_empty, dc_wb_end, inst_flush_end, mmu_flush_end,
    output req_ready, sb_drain, dc_wb_req, inst_flush, mmu_flush, mmu_flush_all,
    output vma_vaddr, vma_asid, done, timeout
  );

  modport slave (
    output req_valid, req_type, req_vaddr, req_asid, req_rs1_zero, req_rs2_zero,
    output sb_empty, dc_wb_end, inst_flush_end, mmu_flush_end,
    input  req_ready, sb_drain, dc_wb_req, inst_flush, mmu_flush, mmu_flush_all,
    input  vma_vaddr, vma_asid, done, timeout
  );
endinterface

// File: rtl/fence_sequencer.sv
// Fence sequencer: drains stores, writes back the dcache, flushes the icache and TLBs for a
// committed FENCE / FENCE.I / SFENCE.VMA, then pulses done so the ROB can retire the fence.
//
//  state    | meaning
//  ---------+--------------------------------------------------
//  S_IDLE   | req_ready high, waiting for a fence at ROB head
//  S_DRAIN  | sb_drain high until the store buffer is empty
//  S_DCWB   | dc_wb_req high until dc_wb_end (FENCE.I only)
//  S_IFLUSH | inst_flush high until inst_flush_end (FENCE.I only)
//  S_MFLUSH | mmu_flush high until mmu_flush_end (SFENCE.VMA only)
//  S_DONE   | done pulse for one cycle, then back to idle
module fence_sequencer #(
  parameter int VADDR_SIZE = 39,
  parameter int ASID_W     = 16,
  parameter int TMO_W      = 16
) (
  input  logic     clk,
  input  logic     rst,
  fence_if.master  bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_DRAIN, S_DCWB, S_IFLUSH, S_MFLUSH, S_DONE
  } state_t;

  localparam logic [TMO_W-1:0] CNT_MAX = '1;

  state_t                state_q;
  logic                  req_ready_q, sb_drain_q, dc_wb_req_q, inst_flush_q, mmu_flush_q;
  logic                  mmu_all_q, done_q, timeout_q, all_q;
  logic [1:0]            type_q;
  logic [VADDR_SIZE-1:0] vaddr_q;
  logic [ASID_W-1:0]     asid_q;
  logic [TMO_W-1:0]      cnt_q, cnt_d;
  logic                  accept, waiting, leave;

  // Watchdog next value: zero on any state change or outside wait states, else saturating +1.
  always_comb begin
    accept  = bus.req_valid & req_ready_q;
    waiting = sb_drain_q | dc_wb_req_q | inst_flush_q | mmu_flush_q;
    leave   = accept | done_q
            | (sb_drain_q   & bus.sb_empty)
            | (dc_wb_req_q  & bus.dc_wb_end)
            | (inst_flush_q & bus.inst_flush_end)
            | (mmu_flush_q  & bus.mmu_flush_end);
    cnt_d = cnt_q;
    if (leave || !waiting) cnt_d = '0;
    else if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
  end

  // Watchdog counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_q | (cnt_d == CNT_MAX);
    end
  end

  // Sequencing FSM. Every handshake level is a register that is set on entry to its state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b1;
      sb_drain_q   <= 1'b0;
      dc_wb_req_q  <= 1'b0;
      inst_flush_q <= 1'b0;
      mmu_flush_q  <= 1'b0;
      mmu_all_q    <= 1'b0;
      done_q       <= 1'b0;
      all_q        <= 1'b0;
      type_q       <= 2'd0;
      vaddr_q      <= '0;
      asid_q       <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            type_q      <= bus.req_type;
            vaddr_q     <= bus.req_rs1_zero ? '0 : bus.req_vaddr;
            asid_q      <= bus.req_rs2_zero ? '0 : bus.req_asid;
            all_q       <= bus.req_rs1_zero & bus.req_rs2_zero;
            req_ready_q <= 1'b0;
            sb_drain_q  <= 1'b1;
            state_q     <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (bus.sb_empty) begin
            sb_drain_q <= 1'b0;
            case (type_q)
              2'd1: begin
                dc_wb_req_q <= 1'b1;
                state_q     <= S_DCWB;
              end
              2'd2: begin
                mmu_flush_q <= 1'b1;
                mmu_all_q   <= all_q;
                state_q     <= S_MFLUSH;
              end
              default: begin
                done_q  <= 1'b1;
                state_q <= S_DONE;
              end
            endcase
          end
        end
        S_DCWB: begin
          if (bus.dc_wb_end) begin
            dc_wb_req_q  <= 1'b0;
            inst_flush_q <= 1'b1;
            state_q      <= S_IFLUSH;
          end
        end
        S_IFLUSH: begin
          if (bus.inst_flush_end) begin
            inst_flush_q <= 1'b0;
            done_q       <= 1'b1;
            state_q      <= S_DONE;
          end
        end
        S_MFLUSH: begin
          if (bus.mmu_flush_end) begin
            mmu_flush_q <= 1'b0;
            mmu_all_q   <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          req_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: begin
          req_ready_q  <= 1'b1;
          sb_drain_q   <= 1'b0;
          dc_wb_req_q  <= 1'b0;
          inst_flush_q <= 1'b0;
          mmu_flush_q  <= 1'b0;
          mmu_all_q    <= 1'b0;
          state_q      <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready     = req_ready_q;
  assign bus.sb_drain      = sb_drain_q;
  assign bus.dc_wb_req     = dc_wb_req_q;
  assign bus.inst_flush    = inst_flush_q;
  assign bus.mmu_flush     = mmu_flush_q;
  assign bus.mmu_flush_all = mmu_all_q;
  assign bus.vma_vaddr     = vaddr_q;
  assign bus.vma_asid      = asid_q;
  assign bus.done          = done_q;
  assign bus.timeout       = timeout_q;
endmodule

// File: tb/tb_fence_sequencer.sv
// Directed bench for fence_sequencer: per-cycle vector table plus hand-written corner sequences.
module tb_fence_sequencer;
  localparam int VA = 39;
  localparam int AW = 16;
  localparam int TW = 10;
  localparam int TMO_MAX = (1 << TW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  fence_if #(.VADDR_SIZE(VA), .ASID_W(AW)) bus ();

  fence_sequencer #(.VADDR_SIZE(VA), .ASID_W(AW), .TMO_W(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // exp = {req_ready, sb_drain, dc_wb_req, inst_flush, mmu_flush, done}, checked after the edge
  typedef struct {
    logic       rst_n;
    logic       rv;
    logic [1:0] typ;
    logic       sbe, dwe, ife, mfe;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic v, input logic [1:0] t, input logic s,
                     input logic d, input logic i, input logic m, input logic [5:0] e);
    vec_t x;
    x.rst_n = r; x.rv = v; x.typ = t; x.sbe = s; x.dwe = d; x.ife = i; x.mfe = m; x.exp = e;
    vecs.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] outs();
    return {bus.req_ready, bus.sb_drain, bus.dc_wb_req, bus.inst_flush, bus.mmu_flush, bus.done};
  endfunction

  task automatic idle_inputs();
    bus.req_valid = 0; bus.req_type = 0; bus.req_vaddr = '0; bus.req_asid = '0;
    bus.req_rs1_zero = 0; bus.req_rs2_zero = 0; bus.sb_empty = 0;
    bus.dc_wb_end = 0; bus.inst_flush_end = 0; bus.mmu_flush_end = 0;
  endtask

  task automatic run_sfence(input string name, input logic [VA-1:0] va, input logic [AW-1:0] as,
                            input logic r1z, input logic r2z, input logic exp_all,
                            input logic [VA-1:0] exp_va, input logic [AW-1:0] exp_as);
    bus.req_valid = 1; bus.req_type = 2; bus.req_vaddr = va; bus.req_asid = as;
    bus.req_rs1_zero = r1z; bus.req_rs2_zero = r2z; bus.sb_empty = 1;
    step();
    bus.req_valid = 0; bus.req_vaddr = '1; bus.req_asid = '1;
    bus.req_rs1_zero = 0; bus.req_rs2_zero = 0;
    step();
    check({name, "_mflush"}, {63'd0, bus.mmu_flush}, 64'd1);
    check({name, "_all"}, {63'd0, bus.mmu_flush_all}, {63'd0, exp_all});
    check({name, "_vaddr"}, {25'd0, bus.vma_vaddr}, {25'd0, exp_va});
    check({name, "_asid"}, {48'd0, bus.vma_asid}, {48'd0, exp_as});
    bus.mmu_flush_end = 1;
    step();
    bus.mmu_flush_end = 0; bus.sb_empty = 0;
    check({name, "_done"}, {58'd0, outs()}, 64'b000001);
    step();
    check({name, "_idle"}, {58'd0, outs()}, 64'b100000);
  endtask

  initial begin
    int acc, dn;

    idle_inputs();
    step(); step();
    check("reset_outs", {58'd0, outs()}, 64'b100000);
    check("reset_regs", {8'd0, bus.mmu_flush_all, bus.timeout, bus.vma_asid, 6'd0, bus.vma_vaddr},
          64'd0);

    // reset held while requesting
    add(0,1,0,1,0,0,0, 6'b100000);
    // FENCE with sb_empty already high: drain at cycle 1, done at 2, ready at 3
    add(1,1,0,1,0,0,0, 6'b010000);
    add(1,0,0,1,0,0,0, 6'b000001);
    add(1,0,0,1,0,0,0, 6'b100000);
    // FENCE.I: stray inst_flush_end in IDLE/DRAIN, late sb_empty, long writeback, short iflush
    add(1,1,1,0,0,1,0, 6'b010000);
    repeat (4) add(1,0,1,0,0,1,0, 6'b010000);
    add(1,0,1,1,0,1,0, 6'b001000);
    repeat (9) add(1,0,1,0,0,1,1, 6'b001000);
    add(1,0,1,0,1,0,0, 6'b000100);
    repeat (2) add(1,0,1,0,0,0,0, 6'b000100);
    add(1,0,1,0,0,1,0, 6'b000001);
    add(1,0,1,0,0,0,0, 6'b100000);
    // SFENCE.VMA: foreign ends ignored while in MFLUSH
    add(1,1,2,1,0,0,1, 6'b010000);
    add(1,0,2,1,0,0,0, 6'b000010);
    add(1,0,2,0,1,1,0, 6'b000010);
    add(1,0,2,0,0,0,1, 6'b000001);
    add(1,0,2,0,0,0,0, 6'b100000);
    // reserved type behaves as FENCE
    add(1,1,3,1,0,0,0, 6'b010000);
    add(1,0,3,1,1,0,0, 6'b000001);
    add(1,0,3,0,0,0,0, 6'b100000);
    // reset in DCWB abandons the sequence
    add(1,1,1,1,0,0,0, 6'b010000);
    add(1,0,1,1,0,0,0, 6'b001000);
    add(0,0,1,0,1,0,0, 6'b100000);
    add(1,0,1,0,0,0,0, 6'b100000);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst_n;
      bus.req_valid = vecs[i].rv; bus.req_type = vecs[i].typ; bus.sb_empty = vecs[i].sbe;
      bus.dc_wb_end = vecs[i].dwe; bus.inst_flush_end = vecs[i].ife;
      bus.mmu_flush_end = vecs[i].mfe;
      step();
      check($sformatf("vec%0d", i), {58'd0, outs()}, {58'd0, vecs[i].exp});
      check($sformatf("vec%0d_onehot", i),
            {63'd0, $onehot0({bus.sb_drain, bus.dc_wb_req, bus.inst_flush, bus.mmu_flush})},
            64'd1);
    end
    rst = 1;
    idle_inputs();
    step();

    run_sfence("sf_addr", 39'h40001000, 16'd7, 0, 0, 0, 39'h40001000, 16'd7);
    run_sfence("sf_x0x0", 39'h123, 16'd9, 1, 1, 1, '0, '0);
    run_sfence("sf_rs1z", 39'h55000, 16'd7, 1, 0, 0, '0, 16'd7);
    run_sfence("sf_rs2z", 39'h55000, 16'd7, 0, 1, 0, 39'h55000, '0);

    // reset during MFLUSH
    bus.req_valid = 1; bus.req_type = 2; bus.sb_empty = 1;
    step();
    bus.req_valid = 0;
    step();
    check("rstm_in_mflush", {63'd0, bus.mmu_flush}, 64'd1);
    rst = 0;
    step();
    check("rstm_outs", {58'd0, outs()}, 64'b100000);
    rst = 1; bus.sb_empty = 0; bus.mmu_flush_end = 1;
    dn = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus.done || bus.mmu_flush) dn++;
    end
    bus.mmu_flush_end = 0;
    check("rstm_no_done", dn, 0);

    // watchdog: exact boundary, stickiness, completion, reset clear
    check("tmo_init", {63'd0, bus.timeout}, 64'd0);
    bus.req_valid = 1; bus.req_type = 0; bus.sb_empty = 0;
    step();
    bus.req_valid = 0;
    repeat (TMO_MAX - 1) step();
    check("tmo_before", {63'd0, bus.timeout}, 64'd0);
    step();
    check("tmo_hit", {63'd0, bus.timeout}, 64'd1);
    repeat (5) step();
    check("tmo_still_wait", {62'd0, bus.timeout, bus.sb_drain}, 64'b11);
    bus.sb_empty = 1;
    step();
    check("tmo_done", {58'd0, outs()}, 64'b000001);
    bus.sb_empty = 0;
    step();
    check("tmo_sticky", {63'd0, bus.timeout}, 64'd1);
    rst = 0;
    step();
    rst = 1;
    check("tmo_cleared", {63'd0, bus.timeout}, 64'd0);

    // req_valid held high: one acceptance per done, 3 cycles per FENCE
    acc = 0; dn = 0;
    bus.req_valid = 1; bus.req_type = 0; bus.sb_empty = 1;
    for (int i = 0; i < 9; i++) begin
      if (bus.req_ready) acc++;
      step();
      if (bus.done) dn++;
    end
    bus.req_valid = 0;
    check("held_accepts", acc, 3);
    check("held_dones", dn, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
